// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle control FSM: opcodes, datapath mux
// encodings, the state enumeration and the per-state (Moore) output decode.
package mc_defs;

  localparam int OPCODE_W = 6;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  // ALU source-B select, shared with SrcBMux
  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_SEXT = 2'b10;
  localparam logic [1:0] SRCB_ZEXT = 2'b11;

  // ALU operation class, shared with the ALU control
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_LOGIC = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_EXEC_IU,
    S_WB_I, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH, S_JUMP
  } mc_state_t;

  typedef struct packed {
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSource;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       regDst;
    logic       memtoReg;
    logic       regWrite;
  } mc_moore_t;

  function automatic mc_moore_t mooreDecode(input mc_state_t s);
    mc_moore_t m;
    m = '0;
    case (s)
      S_FETCH: begin
        m.memRead = 1'b1;
        m.aluSrcB = SRCB_ONE;
      end
      S_DECODE:  m.aluSrcB = SRCB_SEXT;
      S_EXEC_R: begin
        m.aluSrcA = 1'b1;
        m.aluSrcB = SRCB_REGB;
        m.aluOp   = ALUOP_FUNCT;
      end
      S_WB_R: begin
        m.regWrite = 1'b1;
        m.regDst   = 1'b1;
      end
      S_EXEC_I, S_MEMADR: begin
        m.aluSrcA = 1'b1;
        m.aluSrcB = SRCB_SEXT;
        m.aluOp   = ALUOP_ADD;
      end
      S_EXEC_IU: begin
        m.aluSrcA = 1'b1;
        m.aluSrcB = SRCB_ZEXT;
        m.aluOp   = ALUOP_LOGIC;
      end
      S_WB_I:    m.regWrite = 1'b1;
      S_MEMRD: begin
        m.memRead = 1'b1;
        m.iorD    = 1'b1;
      end
      S_MEMWB: begin
        m.regWrite = 1'b1;
        m.memtoReg = 1'b1;
      end
      S_MEMWR: begin
        m.memWrite = 1'b1;
        m.iorD     = 1'b1;
      end
      S_BRANCH: begin
        m.aluSrcA  = 1'b1;
        m.aluSrcB  = SRCB_REGB;
        m.aluOp    = ALUOP_SUB;
        m.pcSource = PCSRC_ALUOUT;
      end
      S_JUMP:    m.pcSource = PCSRC_JUMP;
      default:   m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle FSM (master) and the datapath (slave).
// Memory handshake: MemRead/MemWrite is a request held high every cycle until
// the cycle in which mem_ready=1; that cycle completes the access.
interface multicycle_control_if
  import mc_defs::*;
#(parameter int OP_WIDTH = OPCODE_W) ();

  logic [OP_WIDTH-1:0] opcode;
  logic                zero;
  logic                mem_ready;
  logic                ALUSrcA;
  logic [1:0]          ALUSrcB;
  logic [1:0]          ALUOp;
  logic [1:0]          PCSource;
  logic                PCWrite;
  logic                IorD;
  logic                MemRead;
  logic                MemWrite;
  logic                IRWrite;
  logic                RegDst;
  logic                MemtoReg;
  logic                RegWrite;
  logic                illegal_op;
  mc_state_t           dbgState;

  modport master (
    input  opcode, zero, mem_ready,
    output ALUSrcA, ALUSrcB, ALUOp, PCSource, PCWrite, IorD, MemRead,
           MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, illegal_op, dbgState
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  ALUSrcA, ALUSrcB, ALUOp, PCSource, PCWrite, IorD, MemRead,
           MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, illegal_op, dbgState
  );

endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle datapath. State-only outputs are
// registered alongside the state; PCWrite, IRWrite and illegal_op are Mealy.
module multicycle_control
  import mc_defs::*;
#(parameter int OP_WIDTH = OPCODE_W) (
   input logic clk,
   input logic rst,
   multicycle_control_if.master bus
);

   mc_state_t state, nxt;
   mc_moore_t mooreQ;
   logic      illegalDec;

   always_comb begin
      nxt        = state;
      illegalDec = 1'b0;
      case (state)
         S_RESET:  nxt = S_FETCH;
         S_FETCH:  if (bus.mem_ready) nxt = S_DECODE;
         S_DECODE: begin
            case (bus.opcode)
               OP_WIDTH'(OP_RTYPE):              nxt = S_EXEC_R;
               OP_WIDTH'(OP_LW), OP_WIDTH'(OP_SW): nxt = S_MEMADR;
               OP_WIDTH'(OP_BEQ):                nxt = S_BRANCH;
               OP_WIDTH'(OP_J):                  nxt = S_JUMP;
               OP_WIDTH'(OP_ADDI):               nxt = S_EXEC_I;
               OP_WIDTH'(OP_ANDI), OP_WIDTH'(OP_ORI): nxt = S_EXEC_IU;
               default: begin
                  nxt        = S_FETCH;
                  illegalDec = 1'b1;
               end
            endcase
         end
         S_EXEC_R:  nxt = S_WB_R;
         S_EXEC_I:  nxt = S_WB_I;
         S_EXEC_IU: nxt = S_WB_I;
         // IR is not reloaded until the next FETCH, so opcode is still valid here
         S_MEMADR:  nxt = (bus.opcode == OP_WIDTH'(OP_LW)) ? S_MEMRD : S_MEMWR;
         S_MEMRD:   if (bus.mem_ready) nxt = S_MEMWB;
         S_MEMWR:   if (bus.mem_ready) nxt = S_FETCH;
         default:   nxt = S_FETCH;
      endcase
   end

   // Moore outputs are decoded from the next state so they align with the state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_RESET;
         mooreQ <= '0;
      end else begin
         state  <= nxt;
         mooreQ <= mooreDecode(nxt);
      end
   end

   assign bus.ALUSrcA    = mooreQ.aluSrcA;
   assign bus.ALUSrcB    = mooreQ.aluSrcB;
   assign bus.ALUOp      = mooreQ.aluOp;
   assign bus.PCSource   = mooreQ.pcSource;
   assign bus.IorD       = mooreQ.iorD;
   assign bus.MemRead    = mooreQ.memRead;
   assign bus.MemWrite   = mooreQ.memWrite;
   assign bus.RegDst     = mooreQ.regDst;
   assign bus.MemtoReg   = mooreQ.memtoReg;
   assign bus.RegWrite   = mooreQ.regWrite;
   assign bus.IRWrite    = (state == S_FETCH) && bus.mem_ready;
   assign bus.PCWrite    = ((state == S_FETCH) && bus.mem_ready) ||
                           ((state == S_BRANCH) && bus.zero) ||
                           (state == S_JUMP);
   assign bus.illegal_op = illegalDec;
   assign bus.dbgState   = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: a per-instruction cycle model built
// from the control table predicts every output word, every cycle.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [16:0] exp_q[$];
  bit          rdy_q[$];
  bit          zero_q[$];

  logic [5:0] legal_ops[8] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd2, 6'd8, 6'd12, 6'd13};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {ALUSrcA, ALUSrcB, ALUOp, PCSource, PCWrite, IorD, MemRead, MemWrite,
  //  IRWrite, RegDst, MemtoReg, RegWrite, illegal_op}
  function automatic logic [16:0] mk(input bit asa, input bit [1:0] asb, input bit [1:0] aop,
                                     input bit [1:0] pcs, input bit pcw, input bit iord,
                                     input bit mr, input bit mw, input bit irw, input bit rdst,
                                     input bit m2r, input bit rw, input bit ill);
    return {asa, asb, aop, pcs, pcw, iord, mr, mw, irw, rdst, m2r, rw, ill};
  endfunction

  function automatic logic [16:0] observed();
    return {bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.PCWrite, bus.IorD,
            bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegDst, bus.MemtoReg,
            bus.RegWrite, bus.illegal_op};
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'd0, 6'd35, 6'd43, 6'd4, 6'd2, 6'd8, 6'd12, 6'd13};
  endfunction

  function automatic bit rnd();
    return bit'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [16:0] w, input bit rdy, input bit z);
    exp_q.push_back(w);
    rdy_q.push_back(rdy);
    zero_q.push_back(z);
  endtask

  // Reference model: one entry per clock cycle of the instruction
  task automatic build(input logic [5:0] op, input bit z, input int fs, input int ms);
    for (int i = 0; i < fs; i++)
      push(mk(0, 2'b01, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 0), 1'b0, rnd());
    push(mk(0, 2'b01, 2'b00, 2'b00, 1, 0, 1, 0, 1, 0, 0, 0, 0), 1'b1, rnd());
    push(mk(0, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, !is_legal(op)), rnd(), rnd());
    case (op)
      6'd0: begin
        push(mk(1, 2'b00, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0), rnd(), rnd());
        push(mk(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0, 1, 0), rnd(), rnd());
      end
      6'd8: begin
        push(mk(1, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0), rnd(), rnd());
        push(mk(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0), rnd(), rnd());
      end
      6'd12, 6'd13: begin
        push(mk(1, 2'b11, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0), rnd(), rnd());
        push(mk(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0), rnd(), rnd());
      end
      6'd35: begin
        push(mk(1, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0), rnd(), rnd());
        for (int i = 0; i < ms; i++)
          push(mk(0, 2'b00, 2'b00, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0, 0), 1'b0, rnd());
        push(mk(0, 2'b00, 2'b00, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0, 0), 1'b1, rnd());
        push(mk(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1, 0), rnd(), rnd());
      end
      6'd43: begin
        push(mk(1, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0), rnd(), rnd());
        for (int i = 0; i < ms; i++)
          push(mk(0, 2'b00, 2'b00, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 0), 1'b0, rnd());
        push(mk(0, 2'b00, 2'b00, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 0), 1'b1, rnd());
      end
      6'd4: push(mk(1, 2'b00, 2'b01, 2'b01, z, 0, 0, 0, 0, 0, 0, 0, 0), rnd(), z);
      6'd2: push(mk(0, 2'b00, 2'b00, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0, 0), rnd(), rnd());
      default: ;
    endcase
  endtask

  // abort_after > 0: assert rst asynchronously after that many checked cycles
  task automatic run_instr(input logic [5:0] op, input bit z, input int fs, input int ms,
                           input int abort_after);
    int n;
    int pcw_obs;
    int irw_obs;
    bit both_seen;
    int exp_pcw;
    n = 0; pcw_obs = 0; irw_obs = 0; both_seen = 1'b0;
    exp_pcw = 1 + ((op == 6'd4 && z) ? 1 : 0) + ((op == 6'd2) ? 1 : 0);
    build(op, z, fs, ms);
    while (exp_q.size() > 0) begin
      if (abort_after > 0 && n == abort_after) break;
      @(posedge clk);
      #1;
      bus.mem_ready = rdy_q.pop_front();
      bus.zero      = zero_q.pop_front();
      bus.opcode    = op;
      @(negedge clk);
      check($sformatf("op%0d_cyc%0d", op, n), 32'(observed()), 32'(exp_q.pop_front()));
      pcw_obs += int'(bus.PCWrite);
      irw_obs += int'(bus.IRWrite);
      if (bus.RegWrite && bus.MemWrite) both_seen = 1'b1;
      n++;
    end
    if (abort_after > 0) begin
      #2 rst = 1'b1;
      #1 check("async_reset_clear", 32'(observed()), 32'd0);
      exp_q.delete();
      rdy_q.delete();
      zero_q.delete();
      @(posedge clk);
      @(negedge clk);
      check("reset_hold", 32'(observed()), 32'd0);
      rst = 1'b0;
    end else begin
      check($sformatf("op%0d_pcw_count", op), 32'(pcw_obs), 32'(exp_pcw));
      check($sformatf("op%0d_irw_count", op), 32'(irw_obs), 32'd1);
      check($sformatf("op%0d_rw_mw_excl", op), 32'(both_seen), 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] op;
    bus.opcode    = '0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    rst           = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_state", 32'(observed()), 32'd0);
    rst = 1'b0;

    run_instr(6'd0,  1'b0, 0, 0, 0);   // add
    run_instr(6'd13, 1'b0, 0, 0, 0);   // ori
    run_instr(6'd8,  1'b0, 0, 0, 0);   // addi
    run_instr(6'd12, 1'b0, 0, 0, 0);   // andi
    run_instr(6'd35, 1'b0, 3, 2, 0);   // lw, 10 cycles total
    run_instr(6'd4,  1'b1, 0, 0, 0);   // beq taken
    run_instr(6'd4,  1'b0, 0, 0, 0);   // beq not taken
    run_instr(6'd2,  1'b0, 0, 0, 0);   // j
    run_instr(6'd63, 1'b0, 0, 0, 0);   // illegal
    run_instr(6'd43, 1'b0, 1, 2, 0);   // sw with waits
    run_instr(6'd43, 1'b0, 0, 5, 5);   // sw aborted by reset mid-MEMWR
    run_instr(6'd0,  1'b0, 0, 0, 0);   // first instruction after abort

    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        op = 6'($urandom_range(0, 63));
        while (is_legal(op)) op = 6'($urandom_range(0, 63));
      end else begin
        op = legal_ops[$urandom_range(0, 7)];
      end
      run_instr(op, rnd(), $urandom_range(0, 3), $urandom_range(0, 3), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
